vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator feeding the pixel stages (pattern generators, frame readers) with vga_hc/vga_vc.
//  Runs horizontal/vertical counters on pixel_clk and produces hsync, vsync, video_on and line/frame strobes.
//  Syncs and video_on can be delayed a fixed number of cycles to match the consumer's pixel latency.
// PARAMETERS
//  H_DISPLAY 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48   (H_TOTAL = sum = 800)
//  V_DISPLAY 480 visible lines/frame;  V_FP 10;  V_SYNC 2;   V_BP 33   (V_TOTAL = sum = 525)
//  H_POL 0  hsync active level;  V_POL 0  vsync active level
//  H_SIZE 10  vga_hc width;  V_SIZE 10  vga_vc width (each must hold TOTAL-1)
//  SYNC_DELAY 0  extra cycles on hsync/vsync/video_on relative to vga_hc/vga_vc (0..7)
//  FRAME_W 8  frame_cnt width
// PORTS
//  pixel_clk    in   1        pixel clock
//  reset_n      in   1        asynchronous active-low reset
//  en           in   1        advance raster; 0 = freeze all state
//  vga_hc       out  H_SIZE   horizontal position, 0..H_TOTAL-1
//  vga_vc       out  V_SIZE   vertical position, 0..V_TOTAL-1
//  vga_hsync    out  1        horizontal sync, level H_POL when active
//  vga_vsync    out  1        vertical sync, level V_POL when active
//  video_on     out  1        1 when hc<H_DISPLAY && vc<V_DISPLAY
//  line_start   out  1        1-cycle pulse, vga_hc==0
//  frame_start  out  1        1-cycle pulse, vga_hc==0 && vga_vc==0
//  frame_cnt    out  FRAME_W  frames started since reset, wraps
// BEHAVIOUR
//  - Reset: vga_hc=H_TOTAL-1, vga_vc=V_TOTAL-1 (blanking), hsync=~H_POL, vsync=~V_POL, video_on=0,
//    strobes=0, frame_cnt=0, delay pipe filled with inactive values. First en edge -> (0,0).
//  - en=1 per edge: hc<=hc+1; hc==H_TOTAL-1 -> hc<=0 and vc<=vc+1; vc==V_TOTAL-1 at hc wrap -> vc<=0.
//  - All outputs registered; decodes computed from next-state counters so with SYNC_DELAY=0 they are
//    aligned with vga_hc/vga_vc in the same cycle. No combinational input->output path.
//  - hsync active for hc in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1]; vsync active for vc in
//    [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1] for the whole line (hsync-independent).
//  - frame_cnt increments on the edge that produces frame_start; wraps 2^FRAME_W-1 -> 0.
//  - SYNC_DELAY=N: hsync/vsync/video_on pass through N-stage shift register; strobes and counters undelayed.
//  - en=0: counters, decodes, strobes, delay pipe and frame_cnt all hold; strobes held high remain high
//    (consumers qualify with en). en toggling never skips or repeats a raster position.
//  - reset_n asserted mid-frame: immediate return to reset values; resumes at (0,0) after release.
//  - Width rule: elaboration error if H_TOTAL > 2**H_SIZE or V_TOTAL > 2**V_SIZE or SYNC_DELAY > 7.
// STRUCTURE
//  - Shared timing package/header (vga_timing): H_SIZE/V_SIZE, default 640x480@60 constants, polarities.
//  - Sub-module vga_axis_counter: generic counter + display/sync window decode, instantiated for H
//    (inc=en) and V (inc=en && h_wrap); top adds delay pipe, strobes, frame_cnt.
// TESTING
//  1 reset release, en=1 -> first edge hc=0,vc=0,video_on=1,frame_start=1,line_start=1,frame_cnt=1.
//  2 one line -> video_on=1 hc 0..639, hsync low exactly hc 656..751, hc 799 -> 0 with vc+1.
//  3 one frame -> vsync low exactly vc 490..491 (all hc), video_on=0 for vc>=480, 420000 cycles/frame.
//  4 random en=0 bursts mid-line/at wraps -> sequence of (hc,vc) identical to en=1 reference, no skips.
//  5 reset_n low at hc=300,vc=200 -> outputs at reset values same cycle; after release restart at (0,0).
//  6 SYNC_DELAY=2, FRAME_W=2 -> hsync falls at hc=658 observed; frame_cnt 3 -> 0 on 4th frame start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared raster timing definitions for the VGA sync generator and the pixel
//   stages that consume its vga_hc/vga_vc outputs.
//   - DEF_* constants: default 640x480@60 timing, counter widths and polarities.
//   - sync_bits_t: the group of signals that travel together through the
//     optional sync delay pipe (hsync, vsync, video_on).
//   - fits(): checks that a counter of a given width can reach total-1.
package vga_timing_pkg;

  localparam int   DEF_H_DISPLAY  = 640;
  localparam int   DEF_H_FP       = 16;
  localparam int   DEF_H_SYNC     = 96;
  localparam int   DEF_H_BP       = 48;
  localparam int   DEF_V_DISPLAY  = 480;
  localparam int   DEF_V_FP       = 10;
  localparam int   DEF_V_SYNC     = 2;
  localparam int   DEF_V_BP       = 33;
  localparam logic DEF_H_POL      = 1'b0;
  localparam logic DEF_V_POL      = 1'b0;
  localparam int   DEF_H_SIZE     = 10;
  localparam int   DEF_V_SIZE     = 10;
  localparam int   MAX_SYNC_DELAY = 7;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_bits_t;

  // True when a counter 'size' bits wide can represent 0..total-1.
  function automatic bit fits(input int total, input int size);
    return total <= (1 << size);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis: a wrapping position counter plus the display / sync window
//   decodes. Decodes are taken from the next-state count so that the parent can
//   register them and have them line up with the counter in the same cycle.
// Ports
//   pixel_clk  in   1     pixel clock
//   reset_n    in   1     asynchronous active-low reset (counter -> TOTAL-1)
//   inc        in   1     advance the counter this edge
//   cnt        out  SIZE  registered position, 0..TOTAL-1
//   disp_nxt   out  1     next position lies in the display window
//   sync_nxt   out  1     next position lies in the sync pulse window
//   zero_nxt   out  1     next position is 0
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = DEF_H_DISPLAY,
  parameter int FP      = DEF_H_FP,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BP      = DEF_H_BP,
  parameter int SIZE    = DEF_H_SIZE
) (
  input  logic            pixel_clk,
  input  logic            reset_n,
  input  logic            inc,
  output logic [SIZE-1:0] cnt,
  output logic            disp_nxt,
  output logic            sync_nxt,
  output logic            zero_nxt
);

  localparam int              TOTAL      = DISPLAY + FP + SYNC + BP;
  localparam logic [SIZE-1:0] LAST       = SIZE'(TOTAL - 1);
  localparam logic [SIZE-1:0] DISP_END   = SIZE'(DISPLAY);
  localparam logic [SIZE-1:0] SYNC_FIRST = SIZE'(DISPLAY + FP);
  localparam logic [SIZE-1:0] SYNC_LAST  = SIZE'(DISPLAY + FP + SYNC - 1);

  if (!fits(TOTAL, SIZE)) begin : g_width_err
    $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, SIZE);
  end

  logic [SIZE-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (inc) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + SIZE'(1);
    end
  end

  assign disp_nxt = (cnt_nxt < DISP_END);
  assign sync_nxt = (cnt_nxt >= SYNC_FIRST) && (cnt_nxt <= SYNC_LAST);
  assign zero_nxt = (cnt_nxt == '0);

  // Reset parks the axis on its last position so the first advance lands on 0.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= LAST;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Raster timing generator. Horizontal and vertical axis counters run on
//   pixel_clk while en is high; hsync/vsync/video_on are registered from the
//   next-state decodes and can be delayed SYNC_DELAY extra cycles to match a
//   consumer's pixel latency. Line/frame strobes and frame_cnt stay aligned
//   with vga_hc/vga_vc. en low freezes every register, strobes included.
// Ports
//   pixel_clk    in   1        pixel clock
//   reset_n      in   1        asynchronous active-low reset
//   en           in   1        advance raster; 0 holds all state
//   vga_hc       out  H_SIZE   horizontal position
//   vga_vc       out  V_SIZE   vertical position
//   vga_hsync    out  1        horizontal sync, level H_POL when active
//   vga_vsync    out  1        vertical sync, level V_POL when active
//   video_on     out  1        position inside the visible area
//   line_start   out  1        vga_hc == 0
//   frame_start  out  1        vga_hc == 0 and vga_vc == 0
//   frame_cnt    out  FRAME_W  frames started since reset, wrapping
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY  = DEF_H_DISPLAY,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_DISPLAY  = DEF_V_DISPLAY,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic H_POL      = DEF_H_POL,
  parameter logic V_POL      = DEF_V_POL,
  parameter int   H_SIZE     = DEF_H_SIZE,
  parameter int   V_SIZE     = DEF_V_SIZE,
  parameter int   SYNC_DELAY = 0,
  parameter int   FRAME_W    = 8
) (
  input  logic               pixel_clk,
  input  logic               reset_n,
  input  logic               en,
  output logic [H_SIZE-1:0]  vga_hc,
  output logic [V_SIZE-1:0]  vga_vc,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int                H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam logic [H_SIZE-1:0] H_LAST    = H_SIZE'(H_TOTAL - 1);
  localparam sync_bits_t        SYNC_IDLE = '{hsync: ~H_POL, vsync: ~V_POL, video_on: 1'b0};

  if (SYNC_DELAY < 0 || SYNC_DELAY > MAX_SYNC_DELAY) begin : g_delay_err
    $error("vga_sync_gen: SYNC_DELAY %0d outside 0..%0d", SYNC_DELAY, MAX_SYNC_DELAY);
  end

  logic       h_wrap;
  logic       h_disp_nxt, h_sync_nxt, h_zero_nxt;
  logic       v_disp_nxt, v_sync_nxt, v_zero_nxt;
  sync_bits_t dec_nxt;
  sync_bits_t sync_p [0:SYNC_DELAY];

  // The vertical axis only steps on the edge where the horizontal axis wraps.
  assign h_wrap = en && (vga_hc == H_LAST);

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .SIZE    (H_SIZE)
  ) u_h_axis (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .inc       (en),
    .cnt       (vga_hc),
    .disp_nxt  (h_disp_nxt),
    .sync_nxt  (h_sync_nxt),
    .zero_nxt  (h_zero_nxt)
  );

  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .SIZE    (V_SIZE)
  ) u_v_axis (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .inc       (h_wrap),
    .cnt       (vga_vc),
    .disp_nxt  (v_disp_nxt),
    .sync_nxt  (v_sync_nxt),
    .zero_nxt  (v_zero_nxt)
  );

  always_comb begin
    dec_nxt          = SYNC_IDLE;
    dec_nxt.hsync    = h_sync_nxt ? H_POL : ~H_POL;
    dec_nxt.vsync    = v_sync_nxt ? V_POL : ~V_POL;
    dec_nxt.video_on = h_disp_nxt && v_disp_nxt;
  end

  // Stage p0: decodes registered alongside the counters.
  // Stages p1..pSYNC_DELAY: plain shift of the sync bits, advancing only with en.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      for (int i = 0; i <= SYNC_DELAY; i++) begin
        sync_p[i] <= SYNC_IDLE;
      end
    end else if (en) begin
      line_start  <= h_zero_nxt;
      frame_start <= h_zero_nxt && v_zero_nxt;
      if (h_zero_nxt && v_zero_nxt) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
      sync_p[0] <= dec_nxt;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        sync_p[i] <= sync_p[i-1];
      end
    end
  end

  assign vga_hsync = sync_p[SYNC_DELAY].hsync;
  assign vga_vsync = sync_p[SYNC_DELAY].vsync;
  assign video_on  = sync_p[SYNC_DELAY].video_on;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Three generator instances share one clock:
//   A  default 640x480 timing, no delay  (first edge, line timing, en hold, async reset)
//   B  640-pixel lines, 8-line frames, SYNC_DELAY=2, FRAME_W=2  (delayed hsync, frame_cnt wrap)
//   C  tiny 13x9 raster, H_POL=1, FRAME_W=2  (random en against the reference model)
//   The reference model maps "number of enabled edges since reset" to a raster
//   position with plain division/modulo and evaluates the window rules on it.
module tb_vga_sync_gen;

  typedef struct packed {
    int hd, hfp, hsw, hbp, vd, vfp, vsw, vbp, dly, fw;
    bit hpol, vpol;
  } tim_t;

  typedef struct packed {
    int hc, vc;
    bit hs, vs, vo, ls, fs;
    int fc;
  } obs_t;

  typedef struct packed {
    int   adv;
    obs_t exp;
  } vec_t;

  localparam tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 8, 1'b0, 1'b0};
  localparam tim_t TB = '{640, 16, 96, 48,   4,  1, 1,  2, 2, 2, 1'b0, 1'b0};
  localparam tim_t TC = '{  6,  2,  3,  2,   4,  1, 2,  2, 0, 2, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_en, b_rst_n, b_en, c_rst_n, c_en;
  logic [9:0] a_hc, a_vc;
  logic       a_hs, a_vs, a_vo, a_ls, a_fs;
  logic [7:0] a_fc;
  logic [9:0] b_hc;
  logic [2:0] b_vc;
  logic       b_hs, b_vs, b_vo, b_ls, b_fs;
  logic [1:0] b_fc;
  logic [3:0] c_hc, c_vc;
  logic       c_hs, c_vs, c_vo, c_ls, c_fs;
  logic [1:0] c_fc;

  vga_sync_gen #(
    .H_DISPLAY(TA.hd), .H_FP(TA.hfp), .H_SYNC(TA.hsw), .H_BP(TA.hbp),
    .V_DISPLAY(TA.vd), .V_FP(TA.vfp), .V_SYNC(TA.vsw), .V_BP(TA.vbp),
    .H_POL(TA.hpol), .V_POL(TA.vpol), .H_SIZE(10), .V_SIZE(10),
    .SYNC_DELAY(TA.dly), .FRAME_W(8)
  ) u_a (
    .pixel_clk(clk), .reset_n(a_rst_n), .en(a_en), .vga_hc(a_hc), .vga_vc(a_vc),
    .vga_hsync(a_hs), .vga_vsync(a_vs), .video_on(a_vo), .line_start(a_ls),
    .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_sync_gen #(
    .H_DISPLAY(TB.hd), .H_FP(TB.hfp), .H_SYNC(TB.hsw), .H_BP(TB.hbp),
    .V_DISPLAY(TB.vd), .V_FP(TB.vfp), .V_SYNC(TB.vsw), .V_BP(TB.vbp),
    .H_POL(TB.hpol), .V_POL(TB.vpol), .H_SIZE(10), .V_SIZE(3),
    .SYNC_DELAY(TB.dly), .FRAME_W(2)
  ) u_b (
    .pixel_clk(clk), .reset_n(b_rst_n), .en(b_en), .vga_hc(b_hc), .vga_vc(b_vc),
    .vga_hsync(b_hs), .vga_vsync(b_vs), .video_on(b_vo), .line_start(b_ls),
    .frame_start(b_fs), .frame_cnt(b_fc)
  );

  vga_sync_gen #(
    .H_DISPLAY(TC.hd), .H_FP(TC.hfp), .H_SYNC(TC.hsw), .H_BP(TC.hbp),
    .V_DISPLAY(TC.vd), .V_FP(TC.vfp), .V_SYNC(TC.vsw), .V_BP(TC.vbp),
    .H_POL(TC.hpol), .V_POL(TC.vpol), .H_SIZE(4), .V_SIZE(4),
    .SYNC_DELAY(TC.dly), .FRAME_W(2)
  ) u_c (
    .pixel_clk(clk), .reset_n(c_rst_n), .en(c_en), .vga_hc(c_hc), .vga_vc(c_vc),
    .vga_hsync(c_hs), .vga_vsync(c_vs), .video_on(c_vo), .line_start(c_ls),
    .frame_start(c_fs), .frame_cnt(c_fc)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ka = 0, kb = 0, kc = 0;
  vec_t tbl [10];

  // Expected outputs after k enabled edges since reset release.
  function automatic obs_t ref_model(input tim_t t, input int k);
    obs_t o;
    int ht, vt, fr, p, d, h, v;
    ht = t.hd + t.hfp + t.hsw + t.hbp;
    vt = t.vd + t.vfp + t.vsw + t.vbp;
    fr = ht * vt;
    if (k == 0) begin
      o.hc = ht - 1; o.vc = vt - 1; o.ls = 1'b0; o.fs = 1'b0; o.fc = 0;
    end else begin
      p    = (k - 1) % fr;
      o.hc = p % ht;
      o.vc = p / ht;
      o.ls = (o.hc == 0);
      o.fs = (p == 0);
      o.fc = ((k - 1) / fr + 1) % (1 << t.fw);
    end
    d    = k - t.dly;
    o.hs = ~t.hpol;
    o.vs = ~t.vpol;
    o.vo = 1'b0;
    if (d >= 1) begin
      p = (d - 1) % fr;
      h = p % ht;
      v = p / ht;
      if (h >= t.hd + t.hfp && h < t.hd + t.hfp + t.hsw) o.hs = t.hpol;
      if (v >= t.vd + t.vfp && v < t.vd + t.vfp + t.vsw) o.vs = t.vpol;
      o.vo = (h < t.hd) && (v < t.vd);
    end
    return o;
  endfunction

  function automatic obs_t got_a();
    return '{int'(a_hc), int'(a_vc), a_hs, a_vs, a_vo, a_ls, a_fs, int'(a_fc)};
  endfunction
  function automatic obs_t got_b();
    return '{int'(b_hc), int'(b_vc), b_hs, b_vs, b_vo, b_ls, b_fs, int'(b_fc)};
  endfunction
  function automatic obs_t got_c();
    return '{int'(c_hc), int'(c_vc), c_hs, c_vs, c_vo, c_ls, c_fs, int'(c_fc)};
  endfunction

  task automatic cmp(input string nm, input int k, input obs_t g, input obs_t e);
    n_tests++;
    if (g != e) begin
      n_fail++;
      $display("FAIL %s k=%0d: got hc=%0d vc=%0d hs=%0b vs=%0b vo=%0b ls=%0b fs=%0b fc=%0d, want hc=%0d vc=%0d hs=%0b vs=%0b vo=%0b ls=%0b fs=%0b fc=%0d",
               nm, k, g.hc, g.vc, g.hs, g.vs, g.vo, g.ls, g.fs, g.fc,
               e.hc, e.vc, e.hs, e.vs, e.vo, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // Default 640x480 line, hand-derived: {edges to advance, expected outputs}.
    tbl[0] = '{0,   '{799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0}};
    tbl[1] = '{1,   '{0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1}};
    tbl[2] = '{639, '{639, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1}};
    tbl[3] = '{1,   '{640, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1}};
    tbl[4] = '{15,  '{655, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1}};
    tbl[5] = '{1,   '{656, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1}};
    tbl[6] = '{95,  '{751, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1}};
    tbl[7] = '{1,   '{752, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1}};
    tbl[8] = '{47,  '{799, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1}};
    tbl[9] = '{1,   '{0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1}};

    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
    repeat (3) tick();

    // ---- Instance A: reset release, first edge, one line ----
    a_rst_n = 1'b1;
    a_en    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (tbl[i].adv) begin
        tick();
        ka++;
      end
      cmp($sformatf("a_tbl%0d", i), ka, got_a(), tbl[i].exp);
    end

    // en low: everything, including the high line_start, holds.
    a_en = 1'b0;
    repeat (5) tick();
    cmp("a_hold", ka, got_a(), tbl[9].exp);

    a_en = 1'b1;
    repeat (800) begin
      tick();
      ka++;
      cmp("a_line", ka, got_a(), ref_model(TA, ka));
    end
    repeat (300) begin
      tick();
      ka++;
    end
    cmp("a_pre_rst", ka, got_a(), ref_model(TA, ka));
    chk("a_pre_rst_hc", int'(a_hc), 300);

    // Asynchronous reset mid-line: values change before the next clock edge.
    a_rst_n = 1'b0;
    #2;
    ka = 0;
    cmp("a_async_rst", ka, got_a(), '{799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    tick();
    tick();
    cmp("a_in_rst", ka, got_a(), ref_model(TA, 0));
    a_rst_n = 1'b1;
    tick();
    ka++;
    cmp("a_restart", ka, got_a(), '{0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1});
    a_en = 1'b0;

    // ---- Instance B: delayed syncs, 2-bit frame counter wrap ----
    cmp("b_rst", kb, got_b(), ref_model(TB, 0));
    b_rst_n = 1'b1;
    b_en    = 1'b1;
    while (kb < 19201) begin
      tick();
      kb++;
      if (kb <= 1700 || kb >= 19190) cmp("b_run", kb, got_b(), ref_model(TB, kb));
      if (kb == 658) chk("b_hs_at_657", int'(b_hs), 1);
      if (kb == 659) begin
        chk("b_hc_658", int'(b_hc), 658);
        chk("b_hs_fall_658", int'(b_hs), 0);
      end
      if (kb == 19200) chk("b_fc_before_wrap", int'(b_fc), 3);
      if (kb == 19201) begin
        chk("b_fc_wrap", int'(b_fc), 0);
        chk("b_fs_4th", int'(b_fs), 1);
      end
    end
    b_en = 1'b0;

    // ---- Instance C: random en against the reference model ----
    cmp("c_rst", kc, got_c(), ref_model(TC, 0));
    c_rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      c_en = ($urandom_range(0, 2) != 0);
      tick();
      if (c_en) kc++;
      cmp("c_rand", kc, got_c(), ref_model(TC, kc));
    end

    // Frame period with en held high: 13 x 9 positions.
    c_en = 1'b1;
    cnt  = 0;
    while (!c_fs && cnt < 300) begin
      tick();
      kc++;
      cnt++;
    end
    cnt = 0;
    do begin
      tick();
      kc++;
      cnt++;
    end while (!c_fs && cnt < 300);
    chk("c_frame_period", cnt, 117);
    cmp("c_after_period", kc, got_c(), ref_model(TC, kc));
    c_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
